// File: rtl/iir_biquad_sequencer.sv
// Direct-form-I biquad evaluated over one shared multiplier: five MAC taps, then scale/limit.
// Macro IIR_SAT_EN: clamp out-of-range results (otherwise keep low DATA_WIDTH bits).
module iir_biquad_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    input  logic                         cfg_we,
    input  logic [2:0]                   cfg_addr,
    input  logic signed [DATA_WIDTH-1:0] cfg_data,
    output logic                         cfg_drop,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, SCALE = 2'd2, HOLD = 2'd3} state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] B0_RESET =
        {{(DATA_WIDTH-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

    state_t                         state_r, state_s;
    logic                           accept_s;
    logic [2:0]                     tap_r;
    logic signed [ACC_WIDTH-1:0]    acc_r;
    logic signed [DATA_WIDTH-1:0]   coef_r [0:4];
    logic signed [DATA_WIDTH-1:0]   x0_r, x1_r, x2_r, y1_r, y2_r;
    logic signed [DATA_WIDTH-1:0]   coef_s, opnd_s, lim_s;
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]    prod_ext_s, shifted_s;
    logic                           sub_s, ovf_s;
    logic                           in_ready_r, out_valid_r, cfg_drop_r, ovf_sticky_r;
    logic [31:0]                    out_data_r;

    // Sequencer next-state logic
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s  = MAC;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            MAC: begin
                if (tap_r == 3'd4) state_s = SCALE;
                else               state_s = MAC;
            end
            SCALE: state_s = HOLD;
            HOLD: begin
                if (out_ready) state_s = IDLE;
                else           state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // Tap operand select; feedback taps are subtracted
    always_comb begin
        coef_s = '0;
        opnd_s = '0;
        sub_s  = 1'b0;
        case (tap_r)
            3'd0: begin coef_s = coef_r[0]; opnd_s = x0_r; end
            3'd1: begin coef_s = coef_r[1]; opnd_s = x1_r; end
            3'd2: begin coef_s = coef_r[2]; opnd_s = x2_r; end
            3'd3: begin coef_s = coef_r[3]; opnd_s = y1_r; sub_s = 1'b1; end
            3'd4: begin coef_s = coef_r[4]; opnd_s = y2_r; sub_s = 1'b1; end
            default: sub_s = 1'b0;
        endcase
    end

    assign prod_s     = coef_s * opnd_s;
    assign prod_ext_s = {{(ACC_WIDTH-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
    assign shifted_s  = acc_r >>> FRAC_BITS;

    // Range check and limiting of the scaled accumulator
    always_comb begin
        ovf_s = (shifted_s > ACC_MAX) || (shifted_s < ACC_MIN);
`ifdef IIR_SAT_EN
        if (shifted_s > ACC_MAX)      lim_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (shifted_s < ACC_MIN) lim_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                          lim_s = shifted_s[DATA_WIDTH-1:0];
`else
        lim_s = shifted_s[DATA_WIDTH-1:0];
`endif
    end

    // State, datapath, configuration and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            tap_r        <= 3'd0;
            acc_r        <= '0;
            x0_r         <= '0;
            x1_r         <= '0;
            x2_r         <= '0;
            y1_r         <= '0;
            y2_r         <= '0;
            coef_r[0]    <= B0_RESET;
            coef_r[1]    <= '0;
            coef_r[2]    <= '0;
            coef_r[3]    <= '0;
            coef_r[4]    <= '0;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 32'd0;
            cfg_drop_r   <= 1'b0;
            ovf_sticky_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
            cfg_drop_r <= cfg_we && (state_r != IDLE);
            // Write lands at the same edge as acceptance, so the first tap sees it
            if (cfg_we && (state_r == IDLE) && (cfg_addr < 3'd5)) begin
                coef_r[cfg_addr] <= cfg_data;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r <= '0;
                        x0_r  <= in_data;
                        tap_r <= 3'd0;
                    end
                end
                MAC: begin
                    acc_r <= sub_s ? (acc_r - prod_ext_s) : (acc_r + prod_ext_s);
                    tap_r <= tap_r + 3'd1;
                end
                SCALE: begin
                    out_data_r  <= {{(32-DATA_WIDTH){lim_s[DATA_WIDTH-1]}}, lim_s};
                    out_valid_r <= 1'b1;
                    x2_r        <= x1_r;
                    x1_r        <= x0_r;
                    y2_r        <= y1_r;
                    y1_r        <= lim_s;
                end
                HOLD: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
            if ((state_r == SCALE) && ovf_s) ovf_sticky_r <= 1'b1;
            else if (ovf_clr)                ovf_sticky_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign cfg_drop   = cfg_drop_r;
    assign ovf_sticky = ovf_sticky_r;

endmodule

// File: doc/iir_biquad_sequencer.md
IIR_BIQUAD_SEQUENCER -- requirements
Module: iir_biquad_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning sample and coefficient width (signed).
REQ-002 SHALL have parameter FRAC_BITS, default 14, meaning coefficient fractional bits (Q1.14).
REQ-003 SHALL have parameter ACC_WIDTH, default 40, meaning signed accumulator width.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input sample offered.
REQ-007 SHALL have port in_ready  output  1  sequencer accepts sample.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  signed input sample x[n].
REQ-009 SHALL have port out_valid  output  1  filtered sample available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts output.
REQ-011 SHALL have port out_data  output  32  y[n], sign-extended from DATA_WIDTH.
REQ-012 SHALL have port cfg_we  input  1  coefficient write strobe.
REQ-013 SHALL have port cfg_addr  input  3  coefficient select: 0=b0,1=b1,2=b2,3=a1,4=a2.
REQ-014 SHALL have port cfg_data  input  DATA_WIDTH  signed coefficient value.
REQ-015 SHALL have port cfg_drop  output  1  one-cycle pulse: write rejected.
REQ-016 SHALL have port ovf_sticky  output  1  overflow seen since last clear.
REQ-017 SHALL have port ovf_clr  input  1  clears ovf_sticky.

Function
REQ-018 SHALL compute y[n] = (b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]) >>> FRAC_BITS (arithmetic shift, truncation) using one shared multiplier and one ACC_WIDTH accumulator.
REQ-019 SHALL implement FSM states IDLE, MAC, SCALE, HOLD; IDLE->MAC on in_valid&in_ready; MAC->SCALE after tap 4; SCALE->HOLD; HOLD->IDLE on out_ready.
REQ-020 SHALL assert in_ready only in IDLE.
REQ-021 SHALL clear accumulator on acceptance (cycle T), perform taps 0..4 in cycles T+1..T+5 (one product per cycle, order b0,b1,b2,a1,a2), scale/limit in T+6, assert out_valid from T+7.
REQ-022 SHALL hold out_valid and out_data stable in HOLD until out_ready sampled high; out_valid deasserts the cycle after.
REQ-023 SHALL shift history (x2<=x1, x1<=x[n], y2<=y1, y1<=y[n] limited value) in SCALE.
REQ-024 SHALL accept cfg_we only in IDLE; cfg_addr 5..7 ignored without drop; cfg_we outside IDLE ignored and cfg_drop pulsed for that cycle +1.
REQ-025 SHALL, on cfg_we and sample acceptance in the same IDLE cycle, apply the write first so the accepted sample uses the new coefficient.
REQ-026 SHALL set ovf_sticky in SCALE when shifted result exceeds [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; set wins over simultaneous ovf_clr.
REQ-027 SHALL not stall MAC on out_ready; only HOLD waits.

Reset
REQ-028 SHALL, with rst low at any clock edge (including mid-MAC or HOLD), enter IDLE, drive out_valid=0, out_data=0, in_ready=0 during reset, cfg_drop=0, ovf_sticky=0.
REQ-029 SHALL reset x1,x2,y1,y2,accumulator to 0 and coefficients to pass-through: b0=2^FRAC_BITS (16384), b1=b2=a1=a2=0.
REQ-030 SHALL drop any in-flight sample on reset; no out_valid pulse for it.

Configuration
REQ-031 SHALL honour macro IIR_SAT_EN: defined -> out-of-range result clamped to 32767/-32768; undefined -> result wraps (lower DATA_WIDTH bits kept); ovf_sticky behaviour identical in both.

Verification
REQ-032 Reset defaults, in_data=1000 accepted at T -> out_data=1000, out_valid at T+7, ovf_sticky=0.
REQ-033 b0=b1=b2=16384, three samples 0x7FFF -> third output 32767 with IIR_SAT_EN, 32765 without; ovf_sticky=1 both; ovf_clr -> 0.
REQ-034 a1=-8192 (y+=0.5*y1), b0=16384, impulse 1024 then zeros -> outputs 1024, 512, 256, 128.
REQ-035 out_ready low 10 cycles in HOLD -> out_data stable, in_ready=0, next sample not accepted until after handshake.
REQ-036 cfg_we during MAC -> cfg_drop pulse, coefficient unchanged; rst low at T+3 -> no output, next sample 500 -> out 500 (defaults, history cleared).
